pwm_cfg_ctrl: RTL

- Front-panel controller for the PWM datapath.
- Debounces the up, down and mode buttons, then edits either the frequency-select index or the duty-select index. The mode button picks which one is edited.
- Edited values are handed to the PWM generator through a valid/ack handshake, so a new setting lands only at a PWM period boundary.
- Replaces direct button-to-counter wiring; sits between the board buttons and the PWM generator.

---
 rtl/pwm_cfg_pkg.sv | 18 +
 rtl/pwm_cfg_ctrl_btn_debounce.sv | 54 +++++
 rtl/pwm_cfg_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pwm_cfg_pkg.sv
// Shared types and reset constants for the PWM front-panel controller.
package pwm_cfg_pkg;

  // Controller states: wait for a press, edit, offer to PWM, wait for release.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    COMMIT  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Frequency index after reset.
  localparam int FREQ_RST = 0;

  // Duty index after reset is the mid-scale code: 1 << (DUTY_W - DUTY_RST_SHIFT).
  localparam int DUTY_RST_SHIFT = 1;

endpackage

// File: rtl/pwm_cfg_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and rising-edge pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             press_r;

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has differed from the debounced level for DEB_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r   <= {CNT_W{1'b0}};
      press_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= sync2_r;
      press_r <= sync2_r;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
      press_r <= 1'b0;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/pwm_cfg_ctrl.sv
// Front-panel controller: debounced buttons edit frequency/duty indices, which are handed to the PWM generator via valid/ack.
module pwm_cfg_ctrl
  import pwm_cfg_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int FREQ_W     = 3,
  parameter int DUTY_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_mode,
  input  logic              hold,
  input  logic              cfg_ack,
  output logic [FREQ_W-1:0] freq_sel,
  output logic [DUTY_W-1:0] duty_sel,
  output logic              mode,
  output logic              cfg_valid,
  output logic              busy
);

  localparam logic [FREQ_W-1:0] FREQ_RST_V = FREQ_W'(FREQ_RST);
  localparam logic [DUTY_W-1:0] DUTY_RST_V = DUTY_W'(1) << (DUTY_W - DUTY_RST_SHIFT);
  localparam logic [FREQ_W-1:0] FREQ_MAX   = {FREQ_W{1'b1}};
  localparam logic [DUTY_W-1:0] DUTY_MAX   = {DUTY_W{1'b1}};

  logic lvl_up_s, lvl_down_s, lvl_mode_s;
  logic ev_up_s, ev_down_s, ev_mode_s;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst(rst), .btn(btn_up), .level(lvl_up_s), .press(ev_up_s)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .rst(rst), .btn(btn_down), .level(lvl_down_s), .press(ev_down_s)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .rst(rst), .btn(btn_mode), .level(lvl_mode_s), .press(ev_mode_s)
  );

  state_t            state_r, state_n;
  logic              mode_r, mode_n;
  logic              dir_up_r, dir_up_n;
  logic [FREQ_W-1:0] pend_freq_r, pend_freq_n, freq_cand_s;
  logic [DUTY_W-1:0] pend_duty_r, pend_duty_n, duty_cand_s;
  logic [FREQ_W-1:0] freq_sel_r, freq_sel_n;
  logic [DUTY_W-1:0] duty_sel_r, duty_sel_n;
  logic              cfg_valid_r, cfg_valid_n;
  logic              busy_r;

  // Register all controller state; reset drops any pending offer at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      mode_r      <= 1'b0;
      dir_up_r    <= 1'b0;
      pend_freq_r <= FREQ_RST_V;
      pend_duty_r <= DUTY_RST_V;
      freq_sel_r  <= FREQ_RST_V;
      duty_sel_r  <= DUTY_RST_V;
      cfg_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      mode_r      <= mode_n;
      dir_up_r    <= dir_up_n;
      pend_freq_r <= pend_freq_n;
      pend_duty_r <= pend_duty_n;
      freq_sel_r  <= freq_sel_n;
      duty_sel_r  <= duty_sel_n;
      cfg_valid_r <= cfg_valid_n;
      busy_r      <= (state_n != IDLE);
    end
  end

  // Next-state logic with saturating one-step edit of the selected pending value.
  always_comb begin
    state_n     = state_r;
    mode_n      = mode_r;
    dir_up_n    = dir_up_r;
    pend_freq_n = pend_freq_r;
    pend_duty_n = pend_duty_r;
    freq_sel_n  = freq_sel_r;
    duty_sel_n  = duty_sel_r;
    cfg_valid_n = cfg_valid_r;

    if (dir_up_r) begin
      freq_cand_s = (pend_freq_r == FREQ_MAX) ? pend_freq_r : pend_freq_r + FREQ_W'(1);
      duty_cand_s = (pend_duty_r == DUTY_MAX) ? pend_duty_r : pend_duty_r + DUTY_W'(1);
    end else begin
      freq_cand_s = (pend_freq_r == {FREQ_W{1'b0}}) ? pend_freq_r : pend_freq_r - FREQ_W'(1);
      duty_cand_s = (pend_duty_r == {DUTY_W{1'b0}}) ? pend_duty_r : pend_duty_r - DUTY_W'(1);
    end

    case (state_r)
      IDLE: begin
        if (!hold && ev_mode_s) begin
          mode_n  = ~mode_r;
          state_n = RELEASE;
        end else if (!hold && (ev_up_s ^ ev_down_s)) begin
          dir_up_n = ev_up_s;
          state_n  = APPLY;
        end else begin
          state_n = IDLE;
        end
      end
      APPLY: begin
        if (!mode_r) begin
          if (freq_cand_s == pend_freq_r) begin
            state_n = RELEASE;
          end else begin
            pend_freq_n = freq_cand_s;
            cfg_valid_n = 1'b1;
            state_n     = COMMIT;
          end
        end else begin
          if (duty_cand_s == pend_duty_r) begin
            state_n = RELEASE;
          end else begin
            pend_duty_n = duty_cand_s;
            cfg_valid_n = 1'b1;
            state_n     = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (cfg_ack) begin
          freq_sel_n  = pend_freq_r;
          duty_sel_n  = pend_duty_r;
          cfg_valid_n = 1'b0;
          state_n     = RELEASE;
        end else begin
          state_n = COMMIT;
        end
      end
      RELEASE: begin
        if (!lvl_up_s && !lvl_down_s && !lvl_mode_s) begin
          state_n = IDLE;
        end else begin
          state_n = RELEASE;
        end
      end
      default: begin
        state_n     = IDLE;
        cfg_valid_n = 1'b0;
      end
    endcase
  end

  assign freq_sel  = freq_sel_r;
  assign duty_sel  = duty_sel_r;
  assign mode      = mode_r;
  assign cfg_valid = cfg_valid_r;
  assign busy      = busy_r;

endmodule
